// File: rtl/mni_linkc_tx_queue_pkg.sv
// Shared constants for the MNI LinkC egress queue.
// Flit width and type-field width come from the codebase-wide `FLIT_WIDTH and
// `FLIT_TYPE_WIDTH macros (constants.v); fallbacks are provided so this slice
// elaborates on its own.
// Optional feature macro used by the top level: LINKC_TXQ_STATS_EN.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 34
`endif
`ifndef FLIT_TYPE_WIDTH
`define FLIT_TYPE_WIDTH 2
`endif

package mni_linkc_tx_queue_pkg;

    // FSM encodings, kept as plain constants so existing checkers can match them.
    localparam logic [1:0] TXQ_IDLE  = 2'd0;
    localparam logic [1:0] TXQ_SEND  = 2'd1;
    localparam logic [1:0] TXQ_STALL = 2'd2;

    // Default sizing: queue entries and router input buffer depth.
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_CREDITS = 4;

    // Flit width; the type field is the top `FLIT_TYPE_WIDTH bits.
    localparam int FLIT_W_DEF = `FLIT_WIDTH;

endpackage

// File: rtl/linkc_txq_fifo.sv
// Storage for the LinkC egress queue: circular buffer with read/write
// pointers and an explicit fill count. The caller gates wr_en/rd_en, so this
// block never sees a write to a full queue unless a read happens in the same
// cycle, nor a read from an empty queue.
module linkc_txq_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    // Data array has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wr_data;
    end

    // Pointers wrap naturally modulo DEPTH; count tracks net fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            occupancy <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign rd_data = mem[rptr];
    assign full    = (occupancy == OW'(DEPTH));
    assign empty   = (occupancy == '0);

endmodule

// File: rtl/mni_linkc_tx_queue.sv
// LinkC egress queue between the MNI packetiser and the local router input.
// Flits are buffered and forwarded one per credit; m_LinkC_Status stalls the
// MNI one entry before the queue fills.
//
// Handshake: the MNI side is valid-only (m_data_valid is a write request that
// is either accepted or dropped with overflow_err; m_LinkC_Status is the
// registered stall back to the MNI). The router side is credit based:
// r_data_valid pulses once per flit and only while credit_cnt > 0, and each
// r_credit_in pulse returns one slot.
//
// Optional macro LINKC_TXQ_STATS_EN adds flits_sent / stall_cycles counters.
// fsm_state exposes the controller state for observation.
module mni_linkc_tx_queue
    import mni_linkc_tx_queue_pkg::*;
#(
    parameter int FLIT_W  = FLIT_W_DEF,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int CREDITS = DEF_CREDITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FLIT_W-1:0]            m_data_in,
    input  logic                         m_data_valid,
    output logic                         m_LinkC_Status,
    output logic [FLIT_W-1:0]            r_data_out,
    output logic                         r_data_valid,
    input  logic                         r_credit_in,
    output logic [$clog2(DEPTH):0]       occupancy,
    output logic [$clog2(CREDITS):0]     credit_cnt,
    output logic                         overflow_err,
    output logic                         credit_err,
`ifdef LINKC_TXQ_STATS_EN
    output logic [15:0]                  flits_sent,
    output logic [15:0]                  stall_cycles,
`endif
    output logic [1:0]                   fsm_state
);

    localparam int OW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(CREDITS) + 1;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic              pop;
    logic              wr_acc;
    logic              crd_inc;
    logic [OW-1:0]     occ_nx;
    logic [CW-1:0]     crd_nx;
    logic [FLIT_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;

    linkc_txq_fifo #(
        .W     (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_acc),
        .wr_data   (m_data_in),
        .rd_en     (pop),
        .rd_data   (fifo_rd_data),
        .occupancy (occupancy),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A pop frees an entry in the same cycle, so a write to a full queue is
    // still accepted when it coincides with a pop. A credit at the ceiling
    // only counts when a pop consumes one in the same cycle.
    assign pop     = (state == TXQ_SEND) && (credit_cnt != '0) && !fifo_empty;
    assign wr_acc  = m_data_valid && (!fifo_full || pop);
    assign crd_inc = r_credit_in && ((credit_cnt != CW'(CREDITS)) || pop);

    // Next-cycle fill and credit count; the FSM and status decide on these.
    always_comb begin
        occ_nx = occupancy;
        crd_nx = credit_cnt;
        if (wr_acc)  occ_nx = occ_nx + 1'b1;
        if (pop)     occ_nx = occ_nx - 1'b1;
        if (crd_inc) crd_nx = crd_nx + 1'b1;
        if (pop)     crd_nx = crd_nx - 1'b1;
    end

    // Controller: IDLE when empty, SEND while flits and credits exist,
    // STALL when flits wait for a credit.
    always_comb begin
        state_nx = state;
        case (state)
            TXQ_IDLE: begin
                if (wr_acc) state_nx = (crd_nx != '0) ? TXQ_SEND : TXQ_STALL;
            end
            TXQ_SEND: begin
                if (occ_nx == '0)      state_nx = TXQ_IDLE;
                else if (crd_nx == '0) state_nx = TXQ_STALL;
            end
            TXQ_STALL: begin
                if (crd_nx != '0) state_nx = TXQ_SEND;
            end
            default: state_nx = TXQ_IDLE;
        endcase
    end

    // State, credits, router output register, MNI stall and sticky errors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= TXQ_IDLE;
            credit_cnt     <= CW'(CREDITS);
            r_data_out     <= '0;
            r_data_valid   <= 1'b0;
            m_LinkC_Status <= 1'b0;
            overflow_err   <= 1'b0;
            credit_err     <= 1'b0;
        end else begin
            state          <= state_nx;
            credit_cnt     <= crd_nx;
            r_data_valid   <= pop;
            if (pop) r_data_out <= fifo_rd_data;
            // One entry of slack covers the MNI's one-cycle reaction time.
            m_LinkC_Status <= (occ_nx >= OW'(DEPTH - 1));
            if (m_data_valid && !wr_acc) overflow_err <= 1'b1;
            if (r_credit_in && !crd_inc) credit_err   <= 1'b1;
        end
    end

    assign fsm_state = state;

`ifdef LINKC_TXQ_STATS_EN
    // Free-running statistics; both wrap at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flits_sent   <= '0;
            stall_cycles <= '0;
        end else begin
            if (pop)                flits_sent   <= flits_sent + 16'd1;
            if (state == TXQ_STALL) stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule
